instr_queue: RTL and testbench
==============================

# instr_queue

Decoupling FIFO between `instr_fetch` and the decode stage. Each entry holds a fetched instruction word and its PC. The queue absorbs memory-response bursts and decode stalls, and lets fetch keep a request in flight while decode is blocked. A pipeline `flush` empties it in one cycle so that no wrong-path instruction reaches decode.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; must be a power of two and ≥ 2.

Ports:
- `clk`  in  1: sole clock; all state updates on its rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `fetched`  `decoupled.in`  `fetched_instr_t`: instructions from `instr_fetch` (`.data.pc`, `.data.raw`).
- `decoded_in`  `decoupled.out`  `fetched_instr_t`: head entry presented to decode.
- `flush`  in  1: discards all entries and any push in the same cycle.
- `count`  out  `$clog2(DEPTH)+1`: current occupancy, 0..DEPTH, registered.

## Operation
State:
- Storage array `fetched_instr_t mem[DEPTH]`.
- Read pointer `rp` and write pointer `wp`, each `$clog2(DEPTH)` bits. Both wrap naturally modulo DEPTH.
- Occupancy `cnt`, `$clog2(DEPTH)+1` bits.

Full/empty:
- `empty = (cnt == 0)`.
- `full = (cnt == DEPTH)`.
- Empty and full are derived from `cnt` only, never from pointer equality.

Handshake outputs:
- `fetched.ready = !full`. This is registered state only; there is no combinational path from `decoded_in.ready`.
- `decoded_in.valid = !empty && !flush`.
- `decoded_in.data = mem[rp]`.

Events:
- Push = `fetched.valid && fetched.ready`.
- Pop = `decoded_in.valid && decoded_in.ready`.

Per-cycle update, in priority order:
1. `rst`: `rp`, `wp` and `cnt` go to 0. Array contents are not reset.
2. `flush`: `rp`, `wp` and `cnt` go to 0.
   - A push in the same cycle is accepted by the handshake but its data is dropped.
   - No pop can occur, because `valid` is forced low.
3. Otherwise:
   - Push: write `mem[wp]`, then `wp++`.
   - Pop: `rp++`.
   - `cnt` changes by push − pop. Simultaneous push and pop leaves `cnt` unchanged.
   - When full, push is impossible, so pop only.
   - When empty, pop is impossible. A push sets `cnt` to 1; the entry is **not** bypassed to the output in the same cycle.

Other rules:
- `count = cnt`.
- `rst` asserted mid-operation behaves exactly like flush plus reset: no partial state survives.
- PC and raw bits pass through unmodified. No decode or filtering is done here.

## Timing
- Reset values:
  - `fetched.ready` = 1.
  - `decoded_in.valid` = 0.
  - `count` = 0.
  - `decoded_in.data` = X (don't care).
- Latency: an entry pushed in cycle N is visible at `decoded_in` in cycle N+1 at the earliest.
- Throughput: one push and one pop per cycle sustained at any occupancy 1..DEPTH−1. At full, only a pop is possible in that cycle; the push resumes the following cycle.
- Flush: asserted in cycle N, the queue is empty with `fetched.ready=1` in N+1. `decoded_in.valid` is already low in N.
- `decoded_in.data` must stay stable while `valid && !ready`, per the `decoupled` contract.

## Structure
- `fetched_instr_t` is a packed struct `{ gpreg pc; logic [31:0] raw; }` and lives in `types.sv`. `instr_fetch` drives the same type.
- `gpreg` also comes from `types.sv`. No new package constants are needed.
- One sub-module is natural: `fifo_ctrl`, holding the pointers, count, full/empty and flush logic. It is reusable by later queues such as the LSU store buffer.
- The storage array stays in `instr_queue`.
- Wrap the file in `__INSTR_QUEUE_SV__` include guards and include `types.sv`.

## Test plan
- **Fill/drain, DEPTH=4, decode stalled:** push PCs 0x0, 0x4, 0x8, 0xC.
  - `count` goes 1→4 and `fetched.ready`=0 after the 4th push.
  - After decode is released, the pops return the PCs in order, one per cycle, and `count` returns to 0.
- **Streaming:** push and pop every cycle for 20 cycles starting from `count`=1.
  - `count` stays 1, `fetched.ready` never drops, and the PC order is preserved across pointer wrap.
- **Full plus simultaneous pop:** at `count`=4, assert `fetched.valid` and `decoded_in.ready`.
  - The pop occurs, no push happens that cycle, `count`=3.
  - The next cycle accepts the push, and the new entry appears after the older three.
- **Flush with push:** at `count`=2, assert `flush` and push PC 0x100 together.
  - `decoded_in.valid`=0 that cycle; `count`=0 next cycle.
  - A later push of 0x200 emerges first, and 0x100 never appears.
- **Empty push:** push 0x40 at `count`=0.
  - `decoded_in.valid`=0 in the same cycle.
  - Next cycle `valid`=1 with pc=0x40 and raw unchanged.
- **Reset mid-stream:** assert `rst` for 1 cycle at `count`=3.
  - Next cycle: `count`=0, `valid`=0, `ready`=1.
  - Subsequent traffic behaves as after a clean reset.

Source files
------------

// File: rtl/types.sv
// Shared pipeline types: general-purpose register word and the fetched
// instruction record passed from instr_fetch through instr_queue to decode.
`ifndef __TYPES_SV__
`define __TYPES_SV__

package types;

    typedef logic [31:0] gpreg;

    typedef struct packed {
        gpreg        pc;
        logic [31:0] raw;
    } fetched_instr_t;

endpackage

`endif

// File: rtl/fifo_ctrl.sv
// Pointer/occupancy controller for a power-of-two circular FIFO with a
// one-cycle flush; the storage array itself lives in the instantiating queue.
module fifo_ctrl #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_valid_i,
    input  logic          pop_ready_i,
    output logic          push_ready_o,
    output logic          pop_valid_o,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_ptr_o,
    output logic [AW-1:0] rd_ptr_o,
    output logic [CW-1:0] cnt_o
);

    logic [AW-1:0] rp_q, rp_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full, empty, push, pop;

    // Full/empty come from the count alone so wp == rp is never ambiguous.
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

    assign push_ready_o = !full;
    assign pop_valid_o  = !empty && !flush_i;
    assign push         = push_valid_i && !full;
    assign pop          = pop_valid_o && pop_ready_i;

    // A push accepted during flush or reset still completes the handshake
    // but must not land in the array.
    assign wr_en_o  = push && !flush_i && !rst;
    assign wr_ptr_o = wp_q;
    assign rd_ptr_o = rp_q;
    assign cnt_o    = cnt_q;

    always_comb begin
        rp_d  = rp_q;
        wp_d  = wp_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rp_d  = '0;
            wp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wp_d = wp_q + AW'(1);
            if (pop)  rp_d = rp_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rp_q  <= '0;
            wp_q  <= '0;
            cnt_q <= '0;
        end else begin
            rp_q  <= rp_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_queue.sv
// Decoupling FIFO between instr_fetch and decode; holds {pc, raw} entries
// and empties in a single cycle on a pipeline flush.
`ifndef __INSTR_QUEUE_SV__
`define __INSTR_QUEUE_SV__

`include "types.sv"

module instr_queue
    import types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetched_valid_i,
    output logic                   fetched_ready_o,
    input  fetched_instr_t         fetched_data_i,
    output logic                   decoded_in_valid_o,
    input  logic                   decoded_in_ready_i,
    output fetched_instr_t         decoded_in_data_o,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    fetched_instr_t mem_q [DEPTH];
    logic           wr_en;
    logic [AW-1:0]  wr_ptr, rd_ptr;

    fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .push_valid_i (fetched_valid_i),
        .pop_ready_i  (decoded_in_ready_i),
        .push_ready_o (fetched_ready_o),
        .pop_valid_o  (decoded_in_valid_o),
        .wr_en_o      (wr_en),
        .wr_ptr_o     (wr_ptr),
        .rd_ptr_o     (rd_ptr),
        .cnt_o        (count)
    );

    // The array is not reset; only the pointers decide what is live.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr] <= fetched_data_i;
    end

    assign decoded_in_data_o = mem_q[rd_ptr];

endmodule

`endif

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios with literal
// expectations plus randomized traffic compared against a queue model.
module tb_instr_queue;
    import types::*;

    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           fv;
    logic           fr;
    fetched_instr_t fdata;
    logic           dv;
    logic           dr;
    fetched_instr_t ddata;
    logic [2:0]     count;

    fetched_instr_t model[$];
    int             checks = 0;
    int             errors = 0;

    always #5 clk = ~clk;

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .fetched_valid_i    (fv),
        .fetched_ready_o    (fr),
        .fetched_data_i     (fdata),
        .decoded_in_valid_o (dv),
        .decoded_in_ready_i (dr),
        .decoded_in_data_o  (ddata),
        .flush              (flush),
        .count              (count)
    );

    task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares outputs with the model state while the current inputs are held.
    task automatic checkOutput();
        logic expValid;
        expValid = (model.size() > 0) && !flush;
        checkEq("model count", 64'(count), 64'(model.size()));
        checkEq("model ready", 64'(fr), 64'(model.size() < DEPTH));
        checkEq("model valid", 64'(dv), 64'(expValid));
        if (expValid) checkEq("model data", 64'(ddata), 64'(model[0]));
    endtask

    // One clock cycle: drive, check mid-cycle, advance model, idle inputs.
    task automatic applyStimulus(input logic r, input logic fl, input logic v,
                                 input gpreg pc, input logic [31:0] raw, input logic d);
        logic doPush, doPop;
        rst   = r;
        flush = fl;
        fv    = v;
        fdata = '{pc: pc, raw: raw};
        dr    = d;
        @(negedge clk);
        checkOutput();
        if (r || fl) begin
            model.delete();
        end else begin
            doPush = v && (model.size() < DEPTH);
            doPop  = (model.size() > 0) && d;
            if (doPop)  model.delete(0);
            if (doPush) model.push_back(fdata);
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        flush = 1'b0;
        fv    = 1'b0;
        dr    = 1'b0;
    endtask

    initial begin
        logic [31:0] r32;
        gpreg        expPc [4];

        rst   = 1'b1;
        flush = 1'b0;
        fv    = 1'b0;
        dr    = 1'b0;
        fdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model.delete();

        $display("[TB] reset state");
        checkEq("reset count", 64'(count), 64'd0);
        checkEq("reset ready", 64'(fr), 64'd1);
        checkEq("reset valid", 64'(dv), 64'd0);

        $display("[TB] fill and drain with decode stalled");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, gpreg'(4 * i), $urandom, 1'b0);
            checkEq("fill count", 64'(count), 64'(i + 1));
        end
        checkEq("fill ready low", 64'(fr), 64'd0);
        for (int i = 0; i < 4; i++) begin
            checkEq("drain pc", 64'(ddata.pc), 64'(4 * i));
            applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        end
        checkEq("drain count", 64'(count), 64'd0);

        $display("[TB] streaming across pointer wrap");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h1000, $urandom, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, gpreg'(32'h1000 + 4 * k), $urandom, 1'b1);
            checkEq("stream count", 64'(count), 64'd1);
            checkEq("stream ready", 64'(fr), 64'd1);
            checkEq("stream pc", 64'(ddata.pc), 64'(32'h1000 + 4 * k));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

        $display("[TB] full with simultaneous pop");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, gpreg'(32'h10 + 4 * i), $urandom, 1'b0);
        checkEq("full count", 64'(count), 64'd4);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b1);
        checkEq("full pop count", 64'(count), 64'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0);
        checkEq("refill count", 64'(count), 64'd4);
        expPc = '{32'h14, 32'h18, 32'h1C, 32'h20};
        for (int i = 0; i < 4; i++) begin
            checkEq("full order pc", 64'(ddata.pc), 64'(expPc[i]));
            applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        end

        $display("[TB] flush with push");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h30, $urandom, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h34, $urandom, 1'b0);
        checkEq("preflush count", 64'(count), 64'd2);
        flush = 1'b1;
        fv    = 1'b1;
        #1;
        checkEq("flush valid low", 64'(dv), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h100, $urandom, 1'b0);
        checkEq("flush count", 64'(count), 64'd0);
        checkEq("flush ready", 64'(fr), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h200, $urandom, 1'b0);
        checkEq("postflush valid", 64'(dv), 64'd1);
        checkEq("postflush pc", 64'(ddata.pc), 64'h200);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        checkEq("postflush count", 64'(count), 64'd0);

        $display("[TB] push into empty queue");
        fv = 1'b1;
        #1;
        checkEq("empty push valid low", 64'(dv), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0);
        checkEq("empty push valid", 64'(dv), 64'd1);
        checkEq("empty push pc", 64'(ddata.pc), 64'h40);
        checkEq("empty push raw", 64'(ddata.raw), 64'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, gpreg'(32'h50 + 4 * i), $urandom, 1'b0);
        checkEq("prereset count", 64'(count), 64'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        checkEq("midreset count", 64'(count), 64'd0);
        checkEq("midreset valid", 64'(dv), 64'd0);
        checkEq("midreset ready", 64'(fr), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h500, 32'hCAFE_F00D, 1'b0);
        checkEq("postreset pc", 64'(ddata.pc), 64'h500);
        checkEq("postreset count", 64'(count), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            r32 = $urandom;
            applyStimulus(($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 24) == 0),
                          ($urandom_range(0, 9) < 7),
                          {r32[31:2], 2'b00},
                          $urandom,
                          ($urandom_range(0, 9) < 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
